// File: rtl/mem_demux4.sv
// 1-to-4 load/store request router: registers one request, strobes the slave picked by
// req_addr[SEL_LSB+1:SEL_LSB] until it acks, then returns a 1-cycle response.
// Optional ack timeout is enabled by defining MEM_DEMUX4_TIMEOUT_EN.
module mem_demux4 #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 32,
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  output logic                 rsp_valid,
  output logic [WIDTH-1:0]     rsp_rdata,
  output logic                 rsp_err,
  output logic [3:0]           s_valid,
  output logic                 s_we,
  output logic [ADDR_W-1:0]    s_addr,
  output logic [WIDTH-1:0]     s_wdata,
  input  logic [3:0]           s_ready,
  input  logic [4*WIDTH-1:0]   s_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                    state, state_nxt;
  logic [1:0]                sel;
  logic [3:0]                sel_hot;
  logic [3:0][WIDTH-1:0]     rdata_v;
  logic                      ack;
  logic                      expire;

  for (genvar i = 0; i < 4; i++) begin : g_slave
    assign rdata_v[i] = s_rdata[i*WIDTH +: WIDTH];
    assign sel_hot[i] = (sel == 2'(i));
  end

  assign ack = (state == ISSUE) && s_ready[sel];

`ifdef MEM_DEMUX4_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // Counts completed ISSUE cycles without ack; the TIMEOUT-th such cycle is the expiry cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               wait_cnt <= '0;
    else if (state != ISSUE)  wait_cnt <= '0;
    else if (!ack)            wait_cnt <= wait_cnt + 1'b1;
  end

  assign expire = (state == ISSUE) && !ack && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rsp_err <= 1'b0;
    else if (ack)    rsp_err <= 1'b0;
    else if (expire) rsp_err <= 1'b1;
  end
`else
  assign expire  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid)     state_nxt = ISSUE;
      ISSUE:   if (ack || expire) state_nxt = RESP;
      RESP:                       state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Outputs; ready is masked by rst_n so it reads 0 while reset is held.
  always_comb begin
    req_ready = (state == IDLE) && rst_n;
    rsp_valid = (state == RESP);
    s_valid   = (state == ISSUE) ? sel_hot : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= '0;
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      rsp_rdata <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        sel     <= req_addr[SEL_LSB+1:SEL_LSB];
        s_we    <= req_we;
        s_addr  <= req_addr;
        s_wdata <= req_wdata;
      end
      if (ack)         rsp_rdata <= s_we ? '0 : rdata_v[sel];
      else if (expire) rsp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_mem_demux4.sv
// Randomized scoreboard bench for mem_demux4: the driver pushes expected responses,
// an independent monitor pops them on every rsp_valid pulse.
module tb_mem_demux4;
  localparam int W  = 32;
  localparam int AW = 32;
  localparam int SL = 28;
  localparam int TO = 15;
`ifdef MEM_DEMUX4_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk, rst_n;
  logic            req_valid, req_ready, req_we;
  logic [AW-1:0]   req_addr;
  logic [W-1:0]    req_wdata;
  logic            rsp_valid, rsp_err;
  logic [W-1:0]    rsp_rdata;
  logic [3:0]      s_valid, s_ready;
  logic            s_we;
  logic [AW-1:0]   s_addr;
  logic [W-1:0]    s_wdata;
  logic [4*W-1:0]  s_rdata;

  mem_demux4 #(.WIDTH(W), .ADDR_W(AW), .SEL_LSB(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .s_valid(s_valid), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] rdata;
    logic         err;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   others_hi = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  exp_t e;
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 want no response at %0t", $time);
      end else begin
        e = q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  task automatic scramble_slaves(input logic [1:0] sel, input bit ack, input logic [W-1:0] data);
    logic [3:0] r;
    r = others_hi ? 4'b1111 : 4'($urandom);
    r[sel] = ack;
    s_ready = r;
    for (int i = 0; i < 4; i++) s_rdata[i*W +: W] = $urandom;
    if (ack) s_rdata[sel*W +: W] = data;
  endtask

  // One transaction, entered and left at a negedge in IDLE. d = ack delay in ISSUE cycles.
  task automatic do_txn(input bit we, input logic [AW-1:0] addr, input logic [W-1:0] wdata,
                        input logic [W-1:0] data, input int d);
    logic [1:0] sel;
    bit         err;
    int         nc;
    exp_t       ex;
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    sel = addr[SL+1:SL];
    err = TO_EN && (d >= TO);
    nc  = err ? TO : d + 1;
    ex.rdata = (we || err) ? '0 : data;
    ex.err   = err;
    q.push_back(ex);
    for (int k = 0; k < nc; k++) begin
      @(negedge clk);
      req_we    = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      scramble_slaves(sel, (k == d), data);
      check("s_valid", 64'(s_valid), 64'(4'b0001 << sel));
      check("s_we", 64'(s_we), 64'(we));
      check("s_addr", 64'(s_addr), 64'(addr));
      check("s_wdata", 64'(s_wdata), 64'(wdata));
      check("req_ready_busy", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    scramble_slaves(sel, 1'b0, '0);
    check("resp_cycle", 64'({rsp_valid, req_ready, s_valid}), 64'({1'b1, 1'b0, 4'b0000}));
    @(negedge clk);
    check("post_resp", 64'({rsp_valid, req_ready, s_valid}), 64'({1'b0, 1'b1, 4'b0000}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    s_ready = 4'b1111; s_rdata = '1;
    @(negedge clk); @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_outputs", 64'({rsp_valid, rsp_err, s_valid, s_we}), 64'd0);
    check("rst_regs", 64'({s_addr, rsp_rdata}), 64'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1 check("rst_release_ready", 64'(req_ready), 64'd1);
    @(negedge clk);

    // Idle cycle with no request: nothing should be issued.
    @(negedge clk);
    check("idle_no_issue", 64'(s_valid), 64'd0);

    do_txn(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1);
    do_txn(1'b1, 32'h3000_0004, 32'h1234_5678, 32'hCAFE_F00D, 4);
    others_hi = 1'b1;
    do_txn(1'b0, 32'h2000_0008, 32'h0, 32'h5A5A_A5A5, 2);
    others_hi = 1'b0;
`ifdef MEM_DEMUX4_TIMEOUT_EN
    do_txn(1'b0, 32'h1000_0000, 32'h0, 32'h1111_2222, 100);
    do_txn(1'b0, 32'h1000_0004, 32'h0, 32'h3333_4444, TO - 1);
    do_txn(1'b0, 32'h1000_0008, 32'h0, 32'h5555_6666, TO);
`endif

    // Reset during ISSUE on slave 1: dropped, no response.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1000_0040; req_wdata = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      scramble_slaves(2'd1, 1'b0, '0);
      check("rst_mid_s_valid", 64'(s_valid), 64'(4'b0010));
    end
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1 check("rst_mid_drop", 64'({s_valid, req_ready}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_mid_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_no_rsp", 64'({rsp_valid, s_valid}), 64'd0);

    // Random traffic, mostly back-to-back with occasional idle gaps.
    for (int n = 0; n < 80; n++) begin
      logic [W-1:0] data;
      int d;
      data = $urandom;
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 5);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        @(negedge clk);
        check("gap_no_issue", 64'({s_valid, req_ready}), 64'({4'b0000, 1'b1}));
      end
      do_txn(1'($urandom), $urandom, $urandom, data, d);
    end

    req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
